// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

    // Pointer width needed to address `depth` entries.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Status bundle for arbiter-side consumers that want all flags at once.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the word on an accepted write.
    // NOTE: the storage array has no reset; contents are only meaningful between
    // the pointers, and leaving it unreset lets it map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// optional first-word-fall-through output, flush and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic             rd_acc, wr_acc, ram_we;
    logic [WIDTH-1:0] ram_rdata;
    fifo_status_t     status;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage: writes are suppressed while reset or flush take priority.
    assign ram_we = wr_acc && !flush && !reset;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Flag decode from the registered count plus the sticky error flags.
    always_comb begin
        status.full         = (count_q == CW'(DEPTH));
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= CW'(AF_THRESH));
        status.almost_empty = (count_q <= CW'(AE_THRESH));
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
    end

    // Accept logic: a write while full is allowed only alongside an accepted read.
    assign rd_acc = rd_en && !status.empty;
    assign wr_acc = wr_en && (!status.full || rd_acc);

    // Next-state for pointers, count, error flags and registered output.
    // NOTE: every _d is first given its hold value so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        dout_d      = dout_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            dout_d      = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                dout_d   = ram_rdata;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset overriding everything else.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
        end
    end

    // Output data: head word shown directly in FWFT mode (zero while empty),
    // otherwise the word captured on the last accepted read.
    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = status.empty ? '0 : ram_rdata;
        end else begin : g_reg
            assign dout = dout_q;
        end
    endgenerate

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign count        = count_q;

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: three FIFO configurations share one stimulus stream
// (depth 4 registered, depth 5 registered, depth 4 FWFT) and are compared
// every cycle against a queue-style reference model.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        reset, flush, wr_en, rd_en;
    logic [31:0] din;

    logic [31:0] o_dout  [3];
    logic [2:0]  o_count [3];
    logic        o_full [3], o_empty [3], o_af [3], o_ae [3], o_ovf [3], o_udf [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(32), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_dut4 (
        .clk(clk), .reset(reset), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(o_dout[0]), .full(o_full[0]), .empty(o_empty[0]), .almost_full(o_af[0]),
        .almost_empty(o_ae[0]), .count(o_count[0]), .overflow(o_ovf[0]), .underflow(o_udf[0]));

    sync_fifo_param #(.WIDTH(32), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(2), .FWFT(0)) u_dut5 (
        .clk(clk), .reset(reset), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(o_dout[1]), .full(o_full[1]), .empty(o_empty[1]), .almost_full(o_af[1]),
        .almost_empty(o_ae[1]), .count(o_count[1]), .overflow(o_ovf[1]), .underflow(o_udf[1]));

    sync_fifo_param #(.WIDTH(32), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_dutf (
        .clk(clk), .reset(reset), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(o_dout[2]), .full(o_full[2]), .empty(o_empty[2]), .almost_full(o_af[2]),
        .almost_empty(o_ae[2]), .count(o_count[2]), .overflow(o_ovf[2]), .underflow(o_udf[2]));

    // Per-instance configuration.
    function automatic int dep(input int i);  return (i == 1) ? 5 : 4; endfunction
    function automatic int afth(input int i); return (i == 1) ? 4 : 3; endfunction
    function automatic int aeth(input int i); return (i == 1) ? 2 : 1; endfunction
    function automatic bit fwft(input int i); return (i == 2); endfunction

    // Reference model: element 0 of m_data is always the oldest word.
    int          m_cnt  [3];
    logic [31:0] m_data [3][8];
    logic        m_ovf  [3];
    logic        m_udf  [3];
    logic [31:0] m_dout [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_update(input logic r, input logic f, input logic w,
                                input logic rd, input logic [31:0] d);
        bit racc, wacc;
        for (int i = 0; i < 3; i++) begin
            if (r || f) begin
                m_cnt[i]  = 0;
                m_ovf[i]  = 1'b0;
                m_udf[i]  = 1'b0;
                m_dout[i] = '0;
            end else begin
                racc = rd && (m_cnt[i] > 0);
                wacc = w && ((m_cnt[i] < dep(i)) || racc);
                if (rd && !racc) m_udf[i] = 1'b1;
                if (w && !wacc)  m_ovf[i] = 1'b1;
                if (racc) begin
                    m_dout[i] = m_data[i][0];
                    for (int j = 0; j < 7; j++) m_data[i][j] = m_data[i][j+1];
                    m_cnt[i]--;
                end
                if (wacc) begin
                    m_data[i][m_cnt[i]] = d;
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_dout;
        for (int i = 0; i < 3; i++) begin
            if (fwft(i)) exp_dout = (m_cnt[i] > 0) ? m_data[i][0] : 32'h0;
            else         exp_dout = m_dout[i];
            check($sformatf("i%0d_count", i), 32'(o_count[i]), 32'(m_cnt[i]));
            check($sformatf("i%0d_full", i),  32'(o_full[i]),  32'(m_cnt[i] == dep(i)));
            check($sformatf("i%0d_empty", i), 32'(o_empty[i]), 32'(m_cnt[i] == 0));
            check($sformatf("i%0d_af", i),    32'(o_af[i]),    32'(m_cnt[i] >= afth(i)));
            check($sformatf("i%0d_ae", i),    32'(o_ae[i]),    32'(m_cnt[i] <= aeth(i)));
            check($sformatf("i%0d_ovf", i),   32'(o_ovf[i]),   32'(m_ovf[i]));
            check($sformatf("i%0d_udf", i),   32'(o_udf[i]),   32'(m_udf[i]));
            check($sformatf("i%0d_dout", i),  o_dout[i],       exp_dout);
        end
    endtask

    // One clock of stimulus: drive, let the edge happen, update model, compare at negedge.
    task automatic step(input logic r, input logic f, input logic w,
                        input logic rd, input logic [31:0] d);
        reset = r; flush = f; wr_en = w; rd_en = rd; din = d;
        @(posedge clk);
        model_update(r, f, w, rd, d);
        @(negedge clk);
        compare_all();
    endtask

    int pw, pr;

    initial begin
        reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_dout[i] = 0;
        end

        // Reset state.
        step(1, 0, 0, 0, 32'h0);
        check("rst_empty", 32'(o_empty[0]), 32'd1);

        // Fill and drain.
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 32'hA000_0000 + 32'(k));
        check("t1_full", 32'(o_full[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 32'h0);
            check($sformatf("t1_rd%0d", k), o_dout[0], 32'hA000_0000 + 32'(k));
        end
        check("t1_empty", 32'(o_empty[0]), 32'd1);

        // Overflow: fifth write on the depth-4 instance is dropped.
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 32'hA100_0000 + 32'(k));
        check("t2_ovf", 32'(o_ovf[0]), 32'd1);
        check("t2_cnt", 32'(o_count[0]), 32'd4);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 32'h0);
        check("t2_ovf_sticky", 32'(o_ovf[0]), 32'd1);
        step(0, 1, 1, 1, 32'hDEAD_BEEF);
        check("t2_ovf_flushed", 32'(o_ovf[0]), 32'd0);

        // Full with simultaneous read and write.
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 32'hA200_0000 + 32'(k));
        step(0, 0, 1, 1, 32'hB000_0000);
        check("t3_cnt", 32'(o_count[0]), 32'd4);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 32'h0);
        check("t3_last", o_dout[0], 32'hB000_0000);

        // Empty with simultaneous read and write.
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 1, 32'hC000_0000);
        check("t4_cnt", 32'(o_count[0]), 32'd1);
        check("t4_udf", 32'(o_udf[0]), 32'd1);
        step(0, 0, 0, 1, 32'h0);
        check("t4_dout", o_dout[0], 32'hC000_0000);

        // FWFT: head visible without a read; flush and reset mid-stream.
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'hD000_0000);
        check("t6_fwft_d0", o_dout[2], 32'hD000_0000);
        step(0, 0, 1, 0, 32'hD000_0001);
        step(0, 0, 0, 1, 32'h0);
        check("t6_fwft_d1", o_dout[2], 32'hD000_0001);
        step(0, 0, 1, 0, 32'hD000_0002);
        step(0, 1, 1, 0, 32'hD000_0003);
        check("t6_flush_dout", o_dout[2], 32'h0);
        step(0, 0, 1, 0, 32'hD000_0004);
        step(0, 0, 1, 1, 32'hD000_0005);
        step(1, 0, 1, 1, 32'hD000_0006);
        check("t6_rst_cnt", 32'(o_count[2]), 32'd0);
        check("t6_rst_dout", o_dout[2], 32'h0);

        // Randomised phase with shifting write/read bias to reach full and empty.
        pw = 70; pr = 30;
        for (int c = 0; c < 600; c++) begin
            if (c % 25 == 0) begin
                pw = $urandom_range(10, 90);
                pr = $urandom_range(10, 90);
            end
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < pw),
                 ($urandom_range(0, 99) < pr),
                 $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sync_fifo_param
